h_eqlz_seq: RTL
===============

Name: h_eqlz_seq

Overview:
- Sequenced, registered successor to the combinational equaliser-channel selector.
- Streams one channel coefficient per resource element (RE) to the equaliser for a full subframe of NUM_SC subcarriers × NUM_SYM OFDM symbols.
- Tracks subcarrier and symbol position internally and picks, per RE, between the pilot estimates (est3/est4) and the interpolation divider results (div_res_1/div_res_2).
- Supports NUM_CH parallel lanes (antenna ports) and valid/ready backpressure on both sides.

Parameters:
- WIDTH, 16, bits per coefficient per lane.
- NUM_CH, 1, parallel lanes (all lanes share one selection).
- NUM_SC, 12, subcarriers per symbol.
- NUM_SYM, 14, OFDM symbols per subframe.
- PILOT_SYM_3, 5, symbol index carrying est3; must be less than PILOT_SYM_4.
- PILOT_SYM_4, 6, symbol index carrying est4; must be less than NUM_SYM.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins (or restarts) a subframe.
- in_valid  in  1  upstream RE data valid.
- in_ready  out  1  block accepts the RE this cycle.
- est3  in  NUM_CH*WIDTH  pilot estimate, symbol PILOT_SYM_3; lane k at bits [k*WIDTH +: WIDTH].
- est4  in  NUM_CH*WIDTH  pilot estimate, symbol PILOT_SYM_4.
- div_res_1  in  NUM_CH*WIDTH  interpolation/extrapolation result, early symbols.
- div_res_2  in  NUM_CH*WIDTH  interpolation/extrapolation result, late symbols.
- out_valid  out  1  h_eqlz holds a valid coefficient.
- out_ready  in  1  equaliser accepts the coefficient.
- h_eqlz  out  NUM_CH*WIDTH  selected coefficient.
- sel_out  out  2  selection used (00 div_res_2, 01 est3, 11 est4, 10 div_res_1).
- sc_idx  out  $clog2(NUM_SC)  subcarrier index of h_eqlz.
- sym_idx  out  $clog2(NUM_SYM)  symbol index of h_eqlz.
- frame_done  out  1  one-cycle pulse after the last RE of the subframe drains.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, both counters 0.
- FSM states:
  - IDLE: in_ready=0. start → RUN, with counters cleared.
  - RUN: in_ready = !out_valid || out_ready. Accepting the RE at (sc=NUM_SC-1, sym=NUM_SYM-1) → DRAIN.
  - DRAIN: in_ready=0. When out_valid && out_ready (or out_valid already 0) → IDLE, with frame_done pulsed in that same cycle.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Counter update on each input transfer:
  - sc increments.
  - At sc=NUM_SC-1, sc wraps to 0 and sym increments.
  - sym does not wrap inside a subframe.
- Selection, from the current sym count:
  - sym==PILOT_SYM_3 → est3 (01).
  - sym==PILOT_SYM_4 → est4 (11).
  - sym<PILOT_SYM_3, or PILOT_SYM_3<sym<PILOT_SYM_4 → div_res_1 (10).
  - sym>PILOT_SYM_4 → div_res_2 (00).
- Output register:
  - On an input transfer, h_eqlz/sel_out/sc_idx/sym_idx load the selected lane data and the pre-increment indices; out_valid is set to 1 one cycle later.
  - Latency is 1 cycle.
- Output hold: while out_valid && !out_ready, all output fields hold unchanged and in_ready=0.
- Output clear: out_valid clears on an output transfer with no simultaneous input transfer.
- Full throughput: with in_valid=out_ready=1, one RE per cycle, NUM_SC*NUM_SYM consecutive transfers.
- start during RUN or DRAIN:
  - Aborts the subframe: counters clear, out_valid clears, state goes to RUN.
  - In_ready is forced to 0 in the start cycle, so no input is accepted that cycle.
  - No frame_done pulse for the aborted subframe.
- rst at any time overrides start and all transfers.
- Lanes are independent data paths; no arithmetic is performed and widths pass through unchanged.

Optional Feature:
- Macro: H_EQLZ_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt, 16 bits.
  - Increments each cycle out_valid && !out_ready, saturating at 16'hFFFF.
  - Cleared by rst or start.
- When not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Full subframe, defaults, in_valid=out_ready=1 → 168 output transfers.
  - First h_eqlz appears 1 cycle after the first accept.
  - Symbols 0–4 select div_res_1 (sel 10), symbol 5 est3 (01), symbol 6 est4 (11), symbols 7–13 div_res_2 (00).
  - frame_done pulses exactly once, in the cycle the 168th RE drains.
- Backpressure: hold out_ready=0 for 5 cycles at sc=3, sym=5 → h_eqlz=est3 value, sc_idx=3, sym_idx=5 stable, in_ready=0. Release → resumes with sc=4 and no loss or duplication.
- Wrap: accept RE at sc=11, sym=2 → next output sc_idx=0, sym_idx=3.
- Abort: start at sym=8, sc=6 → out_valid=0 next cycle, counters restart at (0,0), no frame_done. The following full subframe is correct.
- NUM_CH=2, WIDTH=8, est3=16'hA55A, other inputs distinct constants → at sym=5, h_eqlz=16'hA55A, with both lanes selected identically.
- H_EQLZ_STALL_CNT_EN: 7 stall cycles → stall_cnt=7; start → stall_cnt=0.

Source files
------------

// File: rtl/h_eqlz_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : h_eqlz_seq                                                      |
// | Purpose  : Sequenced equaliser-channel selector. Streams one coefficient   |
// |            per resource element over a NUM_SC x NUM_SYM subframe, picking  |
// |            pilot estimates or interpolation results by symbol position.    |
// | Options  : H_EQLZ_STALL_CNT_EN adds a saturating 16-bit output stall count.|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module h_eqlz_seq #(
  parameter int WIDTH       = 16,
  parameter int NUM_CH      = 1,
  parameter int NUM_SC      = 12,
  parameter int NUM_SYM     = 14,
  parameter int PILOT_SYM_3 = 5,
  parameter int PILOT_SYM_4 = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_CH*WIDTH-1:0]    est3,
  input  logic [NUM_CH*WIDTH-1:0]    est4,
  input  logic [NUM_CH*WIDTH-1:0]    div_res_1,
  input  logic [NUM_CH*WIDTH-1:0]    div_res_2,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_CH*WIDTH-1:0]    h_eqlz,
  output logic [1:0]                 sel_out,
  output logic [$clog2(NUM_SC)-1:0]  sc_idx,
  output logic [$clog2(NUM_SYM)-1:0] sym_idx,
`ifdef H_EQLZ_STALL_CNT_EN
  output logic [15:0]                stall_cnt,
`endif
  output logic                       frame_done
);

  localparam int c_SC_W  = $clog2(NUM_SC);
  localparam int c_SYM_W = $clog2(NUM_SYM);
  localparam int c_BUS_W = NUM_CH * WIDTH;

  localparam logic [c_SC_W-1:0]  c_SC_LAST  = c_SC_W'(NUM_SC - 1);
  localparam logic [c_SYM_W-1:0] c_SYM_LAST = c_SYM_W'(NUM_SYM - 1);
  localparam logic [c_SYM_W-1:0] c_PS3      = c_SYM_W'(PILOT_SYM_3);
  localparam logic [c_SYM_W-1:0] c_PS4      = c_SYM_W'(PILOT_SYM_4);

  // Selection codes as seen on sel_out
  localparam logic [1:0] c_SEL_DR2  = 2'b00;
  localparam logic [1:0] c_SEL_EST3 = 2'b01;
  localparam logic [1:0] c_SEL_EST4 = 2'b11;
  localparam logic [1:0] c_SEL_DR1  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [c_SC_W-1:0]    sc_q, sc_d;
  logic [c_SYM_W-1:0]   sym_q, sym_d;

  logic                 out_valid_q;
  logic [c_BUS_W-1:0]   h_q;
  logic [1:0]           sel_q;
  logic [c_SC_W-1:0]    sc_idx_q;
  logic [c_SYM_W-1:0]   sym_idx_q;

  logic                 w_room;
  logic                 w_in_ready;
  logic                 w_frame_done;
  logic                 w_in_xfer;
  logic                 w_out_xfer;
  logic                 w_last_re;
  logic [1:0]           w_sel;
  logic [c_BUS_W-1:0]   w_h;

  // The output slot can take a new RE if empty or being emptied this cycle
  assign w_room     = !out_valid_q || out_ready;
  assign w_last_re  = (sc_q == c_SC_LAST) && (sym_q == c_SYM_LAST);
  assign w_in_xfer  = in_valid && w_in_ready;
  assign w_out_xfer = out_valid_q && out_ready;

  // FSM next state and handshake outputs; start aborts and blocks input for a cycle
  always_comb begin
    state_d      = state_q;
    w_in_ready   = 1'b0;
    w_frame_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (start) begin
          state_d = ST_RUN;
        end else begin
          w_in_ready = w_room;
          if (in_valid && w_room && w_last_re) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (start) begin
          state_d = ST_RUN;
        end else if (w_room) begin
          state_d      = ST_IDLE;
          w_frame_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // RE position: sc advances per accepted RE, sym steps on sc wrap and holds at the last symbol
  always_comb begin
    sc_d  = sc_q;
    sym_d = sym_q;
    if (start) begin
      sc_d  = '0;
      sym_d = '0;
    end else if (w_in_xfer) begin
      if (sc_q == c_SC_LAST) begin
        sc_d = '0;
        if (sym_q != c_SYM_LAST) sym_d = sym_q + c_SYM_W'(1);
      end else begin
        sc_d = sc_q + c_SC_W'(1);
      end
    end
  end

  // Position counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q  <= '0;
      sym_q <= '0;
    end else begin
      sc_q  <= sc_d;
      sym_q <= sym_d;
    end
  end

  // Source selection from the current symbol position
  always_comb begin
    w_sel = c_SEL_DR1;
    if (sym_q == c_PS3)      w_sel = c_SEL_EST3;
    else if (sym_q == c_PS4) w_sel = c_SEL_EST4;
    else if (sym_q > c_PS4)  w_sel = c_SEL_DR2;
  end

  // Every lane follows the same selection; data passes through untouched
  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    assign w_h[k*WIDTH +: WIDTH] =
        (w_sel == c_SEL_EST3) ? est3[k*WIDTH +: WIDTH]      :
        (w_sel == c_SEL_EST4) ? est4[k*WIDTH +: WIDTH]      :
        (w_sel == c_SEL_DR1)  ? div_res_1[k*WIDTH +: WIDTH] :
                                div_res_2[k*WIDTH +: WIDTH];
  end

  // Output register: load on accept, hold while stalled, empty on drain-only cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      h_q         <= '0;
      sel_q       <= '0;
      sc_idx_q    <= '0;
      sym_idx_q   <= '0;
    end else if (start) begin
      out_valid_q <= 1'b0;
    end else if (w_in_xfer) begin
      out_valid_q <= 1'b1;
      h_q         <= w_h;
      sel_q       <= w_sel;
      sc_idx_q    <= sc_q;
      sym_idx_q   <= sym_q;
    end else if (w_out_xfer) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef H_EQLZ_STALL_CNT_EN
  logic [15:0] stall_q;

  // Count cycles a valid coefficient is held back by the equaliser, saturating
  always_ff @(posedge clk) begin
    if (rst || start) begin
      stall_q <= '0;
    end else if (out_valid_q && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

  assign in_ready   = w_in_ready && !rst;
  assign frame_done = w_frame_done && !rst;
  assign out_valid  = out_valid_q;
  assign h_eqlz     = h_q;
  assign sel_out    = sel_q;
  assign sc_idx     = sc_idx_q;
  assign sym_idx    = sym_idx_q;

endmodule
`default_nettype wire
